// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back path: requester indices
// and the architectural register addresses with special handling.
package regfile_wb_arbiter_pkg;

   localparam int unsigned NUM_WB_REQ = 32'd3;

   localparam logic [1:0] REQ_ALU = 2'd0;
   localparam logic [1:0] REQ_LSU = 2'd1;
   localparam logic [1:0] REQ_MDU = 2'd2;

   localparam logic [4:0] REG_ZERO_ADDR = 5'd0;
   localparam logic [4:0] REG_LO_ADDR   = 5'd24;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request found when
// searching upward from ptr_i (wrapping modulo N) wins.
module regfile_wb_arbiter_rr_arbiter #(
   parameter int N = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   // Priority search starting at the pointer
   always_comb begin
      logic [PW-1:0] c;
      c       = {PW{1'b0}};
      grant_o = {N{1'b0}};
      idx_o   = {PW{1'b0}};
      any_o   = 1'b0;
      for (int k = 0; k < N; k++) begin
         c = PW'((int'(ptr_i) + k) % N);
         if (!any_o && req_i[c]) begin
            grant_o[c] = 1'b1;
            idx_o      = c;
            any_o      = 1'b1;
         end else begin
            any_o = any_o;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port, plus the
// pending-write scoreboard that decode uses for RAW stalls.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = NUM_WB_REQ,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wb_stall,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic                            rsv_en,
   input  logic [ADDR_WIDTH-1:0]           rsv_addr,
   output logic [31:0]                     busy_mask,
   output logic                            write_en,
   output logic [ADDR_WIDTH-1:0]           write_addr,
   output logic [DATA_WIDTH-1:0]           write_data
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  write_en_q, write_en_d;
   logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic [31:0]           busy_q, busy_d;

   logic [NUM_REQ-1:0]    req_masked_s;
   logic [NUM_REQ-1:0]    grant_s;
   logic [PTR_W-1:0]      grant_idx_s;
   logic                  grant_any_s;
   logic                  xfer_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [DATA_WIDTH-1:0] sel_data_s;

   assign req_masked_s = req_valid & {NUM_REQ{~wb_stall}};

   regfile_wb_arbiter_rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req_i   (req_masked_s),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant_s),
      .idx_o   (grant_idx_s),
      .any_o   (grant_any_s)
   );

   // Grants are suppressed while reset is held so nothing is accepted and lost
   assign req_ready = rst ? grant_s : {NUM_REQ{1'b0}};
   assign xfer_s    = rst & grant_any_s;

   // Mux the granted requester's address and data
   always_comb begin
      sel_addr_s = {ADDR_WIDTH{1'b0}};
      sel_data_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s[i]) begin
            sel_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
   end

   // Next state for pointer, write channel and scoreboard
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      write_en_d   = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      busy_d       = busy_q;
      if (xfer_s) begin
         rr_ptr_d     = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}}
                                                             : grant_idx_s + PTR_W'(1);
         write_en_d   = (sel_addr_s != ADDR_WIDTH'(REG_ZERO_ADDR));
         write_addr_d = sel_addr_s;
         write_data_d = sel_data_s;
         busy_d[sel_addr_s] = 1'b0;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      // Set after clear: a same-cycle reservation belongs to a younger instruction
      busy_d[rsv_addr] = busy_d[rsv_addr] | rsv_en;
      busy_d[0]        = 1'b0;
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q     <= {PTR_W{1'b0}};
         write_en_q   <= 1'b0;
         write_addr_q <= {ADDR_WIDTH{1'b0}};
         write_data_q <= {DATA_WIDTH{1'b0}};
         busy_q       <= 32'd0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
      end
   end

   assign write_en   = write_en_q;
   assign write_addr = write_addr_q;
   assign write_data = write_data_q;
   assign busy_mask  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a model.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wb_stall = 1'b0;
   logic [2:0]  req_valid = 3'b000;
   logic [2:0]  req_ready;
   logic [14:0] req_addr = 15'd0;
   logic [95:0] req_data = 96'd0;
   logic        rsv_en = 1'b0;
   logic [4:0]  rsv_addr = 5'd0;
   logic [31:0] busy_mask;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;

   int checks = 0;
   int failures = 0;

   regfile_wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .wb_stall   (wb_stall),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .busy_mask  (busy_mask),
      .write_en   (write_en),
      .write_addr (write_addr),
      .write_data (write_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
      req_valid[i]       = v;
      req_addr[i*5 +: 5] = a;
      req_data[i*32 +: 32] = d;
   endtask

   // ---------------- behavioural model ----------------
   int          m_ptr = 0;
   logic        m_wen = 1'b0;
   logic [4:0]  m_waddr = 5'd0;
   logic [31:0] m_wdata = 32'd0;
   logic [31:0] m_busy = 32'd0;

   function automatic int pick(input logic [2:0] v, input int ptr);
      for (int k = 0; k < 3; k++)
         if (v[(ptr + k) % 3]) return (ptr + k) % 3;
      return -1;
   endfunction

   // index of the requester that transfers at the coming edge, or -1
   function automatic int xfer_idx();
      if (!rst || wb_stall) return -1;
      return pick(req_valid, m_ptr);
   endfunction

   function automatic logic [2:0] exp_ready();
      int g;
      g = xfer_idx();
      if (g < 0) return 3'b000;
      return 3'b001 << g;
   endfunction

   function automatic logic [4:0] addr_of(input int i);
      return req_addr[i*5 +: 5];
   endfunction

   function automatic logic [31:0] data_of(input int i);
      return req_data[i*32 +: 32];
   endfunction

   function automatic logic [31:0] busy_next(input logic [31:0] b, input int g);
      logic [31:0] r;
      r = b;
      if (g >= 0 && addr_of(g) != 5'd0) r[addr_of(g)] = 1'b0;
      if (rsv_en && rsv_addr != 5'd0) r[rsv_addr] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ptr   <= 0;
         m_wen   <= 1'b0;
         m_waddr <= 5'd0;
         m_wdata <= 32'd0;
         m_busy  <= 32'd0;
      end else begin
         m_busy <= busy_next(m_busy, xfer_idx());
         if (xfer_idx() >= 0) begin
            m_ptr   <= (xfer_idx() + 1) % 3;
            m_wen   <= (addr_of(xfer_idx()) != 5'd0);
            m_waddr <= addr_of(xfer_idx());
            m_wdata <= data_of(xfer_idx());
         end else begin
            m_wen <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_ready", req_ready, exp_ready());
      chk("m_wen", write_en, m_wen);
      chk("m_waddr", write_addr, m_waddr);
      chk("m_wdata", write_data, m_wdata);
      chk("m_busy", busy_mask, m_busy);
   end

   function automatic logic [4:0] rand_addr();
      int s;
      s = $urandom_range(0, 7);
      if (s == 0) return 5'd0;
      if (s == 1) return 5'd24;
      return 5'($urandom_range(0, 31));
   endfunction

   // ---------------- stimulus ----------------
   logic [4:0]  exp_a [4] = '{5'd1, 5'd2, 5'd3, 5'd1};
   logic [31:0] exp_d [4] = '{32'hA, 32'hB, 32'hC, 32'hA};
   logic [2:0]  exp_r [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
   logic [2:0]  rdy;

   initial begin
      set_req(0, 1'b1, 5'd1, 32'hA);
      set_req(1, 1'b1, 5'd2, 32'hB);
      set_req(2, 1'b1, 5'd3, 32'hC);
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 3'b000);
      chk("rst_wen", write_en, 1'b0);
      chk("rst_busy", busy_mask, 32'd0);
      @(posedge clk); #1; rst = 1'b1;

      // round robin with all three requesting
      @(negedge clk);
      chk("rr_first", req_ready, 3'b001);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rr_wen", write_en, 1'b1);
         chk("rr_addr", write_addr, exp_a[k]);
         chk("rr_data", write_data, exp_d[k]);
         chk("rr_ready", req_ready, exp_r[k]);
      end

      // stall: pointer sits at 2 after the next transfer
      @(posedge clk); #1; wb_stall = 1'b1;
      @(negedge clk); chk("stall_ready0", req_ready, 3'b000);
      @(negedge clk); chk("stall_ready1", req_ready, 3'b000);
      chk("stall_wen", write_en, 1'b0);
      @(posedge clk); #1; wb_stall = 1'b0;
      @(negedge clk); chk("post_stall_ready", req_ready, 3'b100);

      // address 0 and LO alias
      @(posedge clk); #1;
      set_req(0, 1'b0, 5'd0, 32'd0);
      set_req(1, 1'b1, 5'd0, 32'hDEAD);
      set_req(2, 1'b0, 5'd0, 32'd0);
      @(negedge clk); chk("zero_ready", req_ready, 3'b010);
      @(posedge clk); #1;
      set_req(1, 1'b0, 5'd0, 32'd0);
      set_req(2, 1'b1, 5'd24, 32'h1234);
      @(negedge clk);
      chk("zero_wen", write_en, 1'b0);
      chk("lo_ready", req_ready, 3'b100);
      @(posedge clk); #1; set_req(2, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("lo_wen", write_en, 1'b1);
      chk("lo_addr", write_addr, 5'd24);
      chk("lo_data", write_data, 32'h1234);

      // scoreboard set, clear, and same-edge set+clear
      @(posedge clk); #1; rsv_en = 1'b1; rsv_addr = 5'd5;
      @(posedge clk); #1; rsv_en = 1'b0;
      @(negedge clk); chk("sb_set", busy_mask[5], 1'b1);
      @(posedge clk); #1; set_req(0, 1'b1, 5'd5, 32'h55);
      @(posedge clk); #1; set_req(0, 1'b0, 5'd0, 32'd0);
      @(negedge clk); chk("sb_clear", busy_mask[5], 1'b0);
      @(posedge clk); #1; rsv_en = 1'b1; rsv_addr = 5'd5; set_req(0, 1'b1, 5'd5, 32'h56);
      @(posedge clk); #1; rsv_en = 1'b0; set_req(0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("sb_both", busy_mask[5], 1'b1);
      chk("sb_both_wen", write_en, 1'b1);

      // reset between acceptance and the following edge
      @(posedge clk); #1; set_req(1, 1'b1, 5'd7, 32'h77);
      @(posedge clk); #1; set_req(1, 1'b0, 5'd0, 32'd0);
      chk("pre_rst_wen", write_en, 1'b1);
      #2; rst = 1'b0; #1;
      chk("rstmid_wen", write_en, 1'b0);
      chk("rstmid_busy", busy_mask, 32'd0);
      @(posedge clk); #1; rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_wen", write_en, 1'b0);
      end

      // randomized traffic obeying hold-until-ready
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk); rdy = req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            if (!req_valid[i] || rdy[i]) begin
               if ($urandom_range(0, 2) != 0)
                  set_req(i, 1'b1, rand_addr(), $urandom());
               else
                  set_req(i, 1'b0, 5'd0, 32'd0);
            end
         end
         wb_stall = ($urandom_range(0, 4) == 0);
         rsv_en   = ($urandom_range(0, 2) == 0);
         rsv_addr = rand_addr();
         if ($urandom_range(0, 149) == 0) begin
            #3; rst = 1'b0;
            @(posedge clk); #1; rst = 1'b1;
         end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
